// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared states, key codes and keypad geometry for the keypad scanner
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 3;

   localparam logic [3:0] KEY_STAR = 4'd10;
   localparam logic [3:0] KEY_HASH = 4'd11;

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_PRESSED,
      ST_RELEASE
   } scan_state_t;

   // Rows 0..2 form the 1..9 block; row 3 is '*', '0', '#'.
   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      code = 4'd0;
      if (row != 2'd3) begin
         code = 4'(row) * 4'd3 + 4'(col) + 4'd1;
      end else begin
         case (col)
            2'd0:    code = KEY_STAR;
            2'd1:    code = 4'd0;
            default: code = KEY_HASH;
         endcase
      end
      return code;
   endfunction

   function automatic logic [3:0] row_onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   function automatic logic [1:0] lowest_col(input logic [NUM_COLS-1:0] cols);
      logic [1:0] idx;
      idx = 2'd2;
      if (cols[1]) idx = 2'd1;
      if (cols[0]) idx = 2'd0;
      return idx;
   endfunction

endpackage

// File: rtl/scan_tick.sv
// rtl/scan_tick.sv - prescaler producing one-cycle scan ticks every SCAN_DIV gclk cycles
module scan_tick #(
   parameter int SCAN_DIV = 4000
) (
   input  logic gclk,
   input  logic rst,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);

   logic [15:0] count;

   always_ff @(posedge gclk or posedge rst) begin
      if (rst) begin
         count <= 16'd0;
      end else if (count == LAST) begin
         count <= 16'd0;
      end else begin
         count <= count + 16'd1;
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 matrix keypad scanner with press/release debounce
// Drives one row at a time and reports each debounced key once as a key_valid pulse.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 4000,
   parameter int DEBOUNCE_TICKS = 20
) (
   input  logic                gclk,
   input  logic                rst,
   input  logic [NUM_COLS-1:0] keypadc,
   output logic [NUM_ROWS-1:0] keypadr,
   output logic [3:0]          key_code,
   output logic                key_valid,
   output logic                key_held
);

   localparam logic [7:0] DEB_LIM = 8'(DEBOUNCE_TICKS);

   logic                tick;
   logic [NUM_COLS-1:0] col_meta;
   logic [NUM_COLS-1:0] col_sync;
   scan_state_t         state;
   logic [1:0]          row_idx;
   logic [1:0]          col_idx;
   logic [7:0]          deb_cnt;
   logic [7:0]          deb_inc;

   scan_tick #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scan_tick (
      .gclk (gclk),
      .rst  (rst),
      .tick (tick)
   );

   always_ff @(posedge gclk or posedge rst) begin
      if (rst) begin
         col_meta <= '0;
         col_sync <= '0;
      end else begin
         col_meta <= keypadc;
         col_sync <= col_meta;
      end
   end

   assign deb_inc = (deb_cnt == 8'hFF) ? deb_cnt : deb_cnt + 8'd1;

   always_ff @(posedge gclk or posedge rst) begin
      if (rst) begin
         state     <= ST_SCAN;
         row_idx   <= 2'd0;
         col_idx   <= 2'd0;
         deb_cnt   <= 8'd0;
         keypadr   <= 4'b0001;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         case (state)
            ST_SCAN: begin
               if (tick) begin
                  if (col_sync == '0) begin
                     row_idx <= row_idx + 2'd1;
                     keypadr <= row_onehot(row_idx + 2'd1);
                  end else begin
                     col_idx <= lowest_col(col_sync);
                     deb_cnt <= 8'd0;
                     state   <= ST_DEBOUNCE;
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (tick) begin
                  if (col_sync[col_idx]) begin
                     deb_cnt <= deb_inc;
                     if (deb_inc == DEB_LIM) begin
                        state     <= ST_PRESSED;
                        key_code  <= key_map(row_idx, col_idx);
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                     end
                  end else begin
                     state   <= ST_SCAN;
                     row_idx <= row_idx + 2'd1;
                     keypadr <= row_onehot(row_idx + 2'd1);
                  end
               end
            end
            ST_PRESSED: begin
               deb_cnt <= 8'd0;
               state   <= ST_RELEASE;
            end
            ST_RELEASE: begin
               // The pressed row stays driven so release is judged on the same key.
               if (tick) begin
                  if (col_sync == '0) begin
                     deb_cnt <= deb_inc;
                     if (deb_inc == DEB_LIM) begin
                        state    <= ST_SCAN;
                        key_held <= 1'b0;
                        row_idx  <= row_idx + 2'd1;
                        keypadr  <= row_onehot(row_idx + 2'd1);
                     end
                  end else begin
                     deb_cnt <= 8'd0;
                  end
               end
            end
            default: state <= ST_SCAN;
         endcase
      end
   end

endmodule
